thirty_two_bit_multiplier: RTL and testbench
============================================

// Module: thirty_two_bit_multiplier
// PURPOSE
//   Signed 32x32->64 multiplier for the LEGv8 datapath (MUL/SMULH path in the ALU stage).
//   Takes 64-bit register operands, multiplies their low 32-bit halves as two's complement.
//   Registers the full 64-bit product. One result per clock, latency 1 cycle.
//   Built as a radix-4 Booth partial-product array plus an adder tree (no '*' operator).
// PARAMETERS
//   WIDTH   32   operand width used from each input; ports are 2*WIDTH wide
// PORTS
//   clk        in   1    system clock, rising-edge active
//   rst_n      in   1    asynchronous reset, active low
//   in_valid   in   1    operands on a/b are valid this cycle (tie 1 if unused)
//   a          in   64   multiplicand; only a[31:0] used, two's complement
//   b          in   64   multiplier; only b[31:0] used, two's complement
//   product    out  64   signed product of a[31:0] and b[31:0], registered
//   out_valid  out  1    product holds the result of a valid operand pair
// BEHAVIOUR
//   - Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//   - Reset: product = 64'h0, out_valid = 0 immediately on rst_n=0, held until release.
//   - Arithmetic: product = sign_ext64($signed(a[31:0])) * sign_ext64($signed(b[31:0])).
//     Exact, no truncation or overflow possible (|result| <= 2^62).
//   - a[63:32] and b[63:32] are ignored entirely.
//   - Timing: a, b sampled at rising edge N; product valid after edge N, stable until edge N+1.
//   - Throughput: new operands accepted every cycle; no stall, no backpressure.
//   - product register loads every cycle regardless of in_valid.
//   - out_valid is in_valid delayed by one cycle.
//   - Datapath:
//     - 17 radix-4 Booth digits from {b[31:0],1'b0} select 0/+-a/+-2a.
//     - Partial products are sign-extended to 64 bits and summed combinationally.
//     - The sum feeds the output register.
//   - Boundaries:
//     - 0x80000000*0x80000000 = 64'h4000_0000_0000_0000.
//     - 0x80000000*0x7FFFFFFF = 64'hC000_0000_8000_0000.
//     - Any operand 0 gives 0 (no -0 artefacts).
//   - Reset mid-stream: the in-flight result is discarded and out_valid=0 on the first edge after release.
// CONFIGURATION
//   MULT_INPUT_REG_EN:
//     - defined: adds an input register stage for a/b/in_valid (also reset to 0).
//     - Latency becomes 2 cycles; throughput stays 1/cycle.
//   - undefined: latency 1 cycle as above (default build).
// TESTING
//   1. Assert rst_n=0 with a=5, b=7 -> product=0, out_valid=0; release -> product=35 one cycle later.
//   2. a=b=i for i=0..999, one per cycle -> product(i)=i*i one cycle later, upper 32 bits 0.
//   3. a={32'h0,i}, b={32'hFFFFFFFF,~i} for i=0..999 -> product = -(i*(i+1)) as 64-bit.
//      Checks: i=0 -> 0; i=3 -> 64'hFFFF_FFFF_FFFF_FFF4.
//   4. Corners:
//      - 0x80000000*0x80000000 -> 64'h4000000000000000.
//      - 0xFFFFFFFF*0xFFFFFFFF -> 1.
//      - 0x7FFFFFFF*0x7FFFFFFF -> 64'h3FFFFFFF00000001.
//   5. Upper halves ignored: a=64'hDEAD_BEEF_0000_0002, b=64'h1234_5678_0000_0003 -> 6.
//   6. Random signed pairs back-to-back with in_valid toggling
//      -> product matches reference every cycle; out_valid tracks in_valid with latency 1
//         (2 with MULT_INPUT_REG_EN).

Source files
------------

// File: rtl/thirty_two_bit_multiplier.sv
// rtl/thirty_two_bit_multiplier.sv - signed 32x32->64 radix-4 Booth multiplier, registered product
// Optional build macro: MULT_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).

module thirty_two_bit_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [2*WIDTH-1:0] a,
    input  logic [2*WIDTH-1:0] b,
    output logic [2*WIDTH-1:0] product,
    output logic               out_valid
);

    localparam int PW   = 2 * WIDTH;
    localparam int NDIG = WIDTH / 2 + 1;
    localparam int TREE = 1 << $clog2(NDIG);

    // Upper operand halves carry no meaning for this multiplier.
    logic unused_upper;
    assign unused_upper = ^{a[PW-1:WIDTH], b[PW-1:WIDTH]};

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_valid;

`ifdef MULT_INPUT_REG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             in_valid_q;

    // Input stage: capture the used operand halves and their valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            in_valid_q <= 1'b0;
        end else begin
            a_q        <= a[WIDTH-1:0];
            b_q        <= b[WIDTH-1:0];
            in_valid_q <= in_valid;
        end
    end

    assign op_a     = a_q;
    assign op_b     = b_q;
    assign op_valid = in_valid_q;
`else
    assign op_a     = a[WIDTH-1:0];
    assign op_b     = b[WIDTH-1:0];
    assign op_valid = in_valid;
`endif

    // Multiplicand multiples selectable by a Booth digit.
    logic [PW-1:0] a_pos;
    logic [PW-1:0] a_neg;
    logic [PW-1:0] a2_pos;
    logic [PW-1:0] a2_neg;

    assign a_pos  = {{WIDTH{op_a[WIDTH-1]}}, op_a};
    assign a_neg  = (~a_pos) + PW'(1);
    assign a2_pos = a_pos << 1;
    assign a2_neg = a_neg << 1;

    // Multiplier with the implicit zero below bit 0 and two sign bits on top,
    // so the last digit (always 0 for a signed operand) stays well defined.
    logic [WIDTH+2:0] b_ext;
    assign b_ext = {{2{op_b[WIDTH-1]}}, op_b, 1'b0};

    logic [PW-1:0] pp [NDIG];

    // Booth recoding: each overlapping bit triplet picks 0, +-a or +-2a, weighted by 4^j.
    always_comb begin
        logic [2:0]    digit;
        logic [PW-1:0] sel;
        digit = 3'b000;
        sel   = '0;
        for (int j = 0; j < NDIG; j++) begin
            digit = b_ext[2*j +: 3];
            case (digit)
                3'b001, 3'b010: sel = a_pos;
                3'b011:         sel = a2_pos;
                3'b100:         sel = a2_neg;
                3'b101, 3'b110: sel = a_neg;
                default:        sel = '0;
            endcase
            pp[j] = sel << (2 * j);
        end
    end

    logic [PW-1:0] tree [TREE];

    // Pairwise adder tree over the partial products, padded with zeros to a power of two.
    always_comb begin
        for (int i = 0; i < TREE; i++) begin
            tree[i] = (i < NDIG) ? pp[i] : '0;
        end
        for (int s = 1; s < TREE; s = s * 2) begin
            for (int i = 0; i < TREE; i = i + 2 * s) begin
                tree[i] = tree[i] + tree[i + s];
            end
        end
    end

    logic [PW-1:0] product_d;
    logic [PW-1:0] product_q;
    logic          out_valid_d;
    logic          out_valid_q;

    assign product_d   = tree[0];
    assign out_valid_d = op_valid;

    // Output stage: product loads every cycle, valid follows the operand valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign product   = product_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_thirty_two_bit_multiplier.sv
// tb/tb_thirty_two_bit_multiplier.sv - self-checking bench for thirty_two_bit_multiplier

module tb_thirty_two_bit_multiplier;

`ifdef MULT_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] product;
    logic        out_valid;

    int tests_run;
    int tests_failed;

    logic [63:0] q_exp [$];
    logic        q_v   [$];

    thirty_two_bit_multiplier #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .product   (product),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [63:0] av, input logic [63:0] bv);
        longint sa;
        longint sb;
        sa = longint'($signed(av[31:0]));
        sb = longint'($signed(bv[31:0]));
        return 64'(sa * sb);
    endfunction

    // One clock: drive operands, then compare the output due this cycle.
    task automatic step(input logic [63:0] av, input logic [63:0] bv, input logic v);
        logic [63:0] e;
        logic        ev;
        a        = av;
        b        = bv;
        in_valid = v;
        q_exp.push_back(ref_mul(av, bv));
        q_v.push_back(v);
        @(posedge clk);
        #1;
        if (q_exp.size() >= LAT) begin
            e  = q_exp.pop_front();
            ev = q_v.pop_front();
            check("product", product, e);
            check("out_valid", {63'b0, out_valid}, {63'b0, ev});
        end
    endtask

    // Hold one operand pair long enough for it to reach the output, then compare to a constant.
    task automatic corner(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] exp);
        repeat (LAT) step(av, bv, 1'b1);
        check(tag, product, exp);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] picks [6];
        logic [31:0] ii;

        tests_run    = 0;
        tests_failed = 0;
        picks[0] = 64'h0000_0000_8000_0000;
        picks[1] = 64'h0000_0000_7FFF_FFFF;
        picks[2] = 64'h0000_0000_FFFF_FFFF;
        picks[3] = 64'h0000_0000_0000_0000;
        picks[4] = 64'h0000_0000_0000_0001;
        picks[5] = 64'hFFFF_FFFF_0000_0000;

        // Test 1: reset with operands present
        rst_n    = 1'b0;
        a        = 64'd5;
        b        = 64'd7;
        in_valid = 1'b1;
        #1;
        check("rst_product_async", product, 64'h0);
        check("rst_valid_async", {63'b0, out_valid}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_product_held", product, 64'h0);
        check("rst_valid_held", {63'b0, out_valid}, 64'h0);
        rst_n = 1'b1;
        corner("rst_release_35", 64'd5, 64'd7, 64'd35);

        // Test 2: squares
        for (int i = 0; i < 1000; i++) begin
            step(64'(i), 64'(i), 1'b1);
        end
        corner("square_999", 64'd999, 64'd999, 64'd998001);

        // Test 3: i * -(i+1)
        for (int i = 0; i < 1000; i++) begin
            ii = 32'(i);
            step({32'h0, ii}, {32'hFFFF_FFFF, ~ii}, 1'b1);
        end
        corner("neg_i0", 64'h0, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 64'h0);
        corner("neg_i3", 64'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFC}, 64'hFFFF_FFFF_FFFF_FFF4);

        // Test 4: corners
        corner("min_x_min", 64'h8000_0000, 64'h8000_0000, 64'h4000_0000_0000_0000);
        corner("min_x_max", 64'h8000_0000, 64'h7FFF_FFFF, 64'hC000_0000_8000_0000);
        corner("m1_x_m1", 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h1);
        corner("max_x_max", 64'h7FFF_FFFF, 64'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        corner("zero_x_min", 64'h0, 64'h8000_0000, 64'h0);
        corner("m1_x_zero", 64'hFFFF_FFFF, 64'h0, 64'h0);

        // Test 5: upper halves ignored
        corner("upper_ignored", 64'hDEAD_BEEF_0000_0002, 64'h1234_5678_0000_0003, 64'd6);

        // Test 6: random back-to-back with in_valid toggling
        for (int i = 0; i < 600; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) ra = picks[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) rb = picks[$urandom_range(0, 5)];
            step(ra, rb, 1'($urandom_range(0, 1)));
        end

        // Reset mid-stream discards the in-flight result
        step(64'h1234_5678, 64'h9ABC_DEF0, 1'b1);
        step(64'h0FED_CBA9, 64'h8765_4321, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_product", product, 64'h0);
        check("midrst_valid", {63'b0, out_valid}, 64'h0);
        q_exp.delete();
        q_v.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_product_edge", product, 64'h0);
        rst_n = 1'b1;
        step(64'd3, 64'd4, 1'b0);
        check("post_rst_valid", {63'b0, out_valid}, 64'h0);
        for (int i = 0; i < 50; i++) begin
            step({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
